// File: rtl/uart_tx_pacer_if.sv
// Byte-strobe bundle between the producer, the pacer and uart_tx.
// The master drives the write strobe; the slave (pacer) drives the paced output and queue status.
interface uart_tx_pacer_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      pi_data;
  logic            pi_flag;
  logic [7:0]      po_data;
  logic            po_flag;
  logic            full;
  logic [ADDR_W:0] level;
  logic            overflow;

  modport master (
    output pi_data,
    output pi_flag,
    input  po_data,
    input  po_flag,
    input  full,
    input  level,
    input  overflow
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output po_data,
    output po_flag,
    output full,
    output level,
    output overflow
  );
endinterface

// File: rtl/uart_tx_pacer.sv
// Byte FIFO plus frame-rate pacer feeding uart_tx: one po_flag strobe per UART frame time, write-to-strobe 2 cycles when idle.
// No backpressure upstream: a write into a full queue is dropped and reported by a one-cycle overflow pulse.
module uart_tx_pacer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FRAME_BITS = 10,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_tx_pacer_if.slave bus
);

  localparam int BIT_CYCLES   = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS;
  localparam int CNT_W        = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int LVL_W        = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [0:0]        state;
  logic              wr_en;
  logic              rd_en;
  logic [LVL_W-1:0]  level_nxt;

  // A pop happens only from IDLE, so a read never needs a write bypass (level is already non-zero).
  always_comb begin
    wr_en     = bus.pi_flag && (bus.level != LVL_FULL);
    rd_en     = (state == IDLE) && (bus.level != '0);
    level_nxt = bus.level;
    if (wr_en && !rd_en) begin
      level_nxt = bus.level + LVL_ONE;
    end else if (rd_en && !wr_en) begin
      level_nxt = bus.level - LVL_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.pi_data;
    end
  end

  // Overflow looks at the pre-edge level, so a simultaneous pop does not rescue a write into a full queue.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.level    <= '0;
      bus.full     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      bus.level    <= level_nxt;
      bus.full     <= (level_nxt == LVL_FULL);
      bus.overflow <= bus.pi_flag && (bus.level == LVL_FULL);
    end
  end

  // Leaving WAIT at FRAME_CYCLES-2 plus the IDLE pop edge spaces strobes exactly FRAME_CYCLES apart.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.po_data <= 8'h00;
      bus.po_flag <= 1'b0;
    end else begin
      bus.po_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_en) begin
            bus.po_data <= mem[rd_ptr];
            bus.po_flag <= 1'b1;
            cnt         <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
